// File: rtl/ppu_pkg.sv
// Shared PPU types: operation stream encoding, normalizer FSM states,
// and the accumulator fixed-point format defaults.
package ppu_pkg;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_FMADD
    } operation_e;

    typedef enum logic [1:0] {
        NORM_IDLE,
        NORM_RUN,
        NORM_OUT
    } fma_norm_state_e;

    // Fixed-point accumulator format, shared with the accumulator.
    localparam int FMA_FX_M          = 31;
    localparam int FMA_FX_B          = 64;
    localparam int FMA_FIR_TE_SIZE   = 7;
    localparam int FMA_FIR_FRAC_SIZE = 14;
    localparam int FMA_SHIFT_STEP    = 8;
    localparam int FMA_FIR_W         = 1 + FMA_FIR_TE_SIZE + FMA_FIR_FRAC_SIZE;

    // Sign/magnitude view of an accumulator value.
    typedef struct packed {
        logic                sign;
        logic [FMA_FX_B-1:0] mag;
    } fma_fx_sm_t;

endpackage

// File: rtl/fma_acc_normalizer_if.sv
// Result handshake bundle of the accumulator normalizer.
// master: fir_o/zero_o/sticky_o/valid_o out, ready_i in; slave mirrors it.
interface fma_acc_normalizer_if #(
    parameter int FIR_W = 22
);
    logic [FIR_W-1:0] fir_o;
    logic             zero_o;
    logic             sticky_o;
    logic             valid_o;
    logic             ready_i;

    modport master (
        output fir_o,
        output zero_o,
        output sticky_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  fir_o,
        input  zero_o,
        input  sticky_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/fma_acc_normalizer.sv
// Normalizes the FMA accumulator at the end of each FMADD burst into a
// {sign, te, mant} FIR, with a one-entry pending slot for back-to-back bursts.
// Ports: clk_i, rst_i (sync, active-high), op_i, fixed_i,
//   res_if (master: fir_o, zero_o, sticky_o, valid_o, ready_i),
//   busy_o (FSM not idle), overrun_o (1-cycle pulse: burst end dropped).
// Build option: FMA_NORM_STICKY_EN drives sticky_o from the discarded low bits.
module fma_acc_normalizer
    import ppu_pkg::*;
#(
    parameter int FX_M          = FMA_FX_M,
    parameter int FX_B          = FMA_FX_B,
    parameter int FIR_TE_SIZE   = FMA_FIR_TE_SIZE,
    parameter int FIR_FRAC_SIZE = FMA_FIR_FRAC_SIZE,
    parameter int SHIFT_STEP    = FMA_SHIFT_STEP
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  operation_e                  op_i,
    input  logic [FX_B-1:0]             fixed_i,
    fma_acc_normalizer_if.master        res_if,
    output logic                        busy_o,
    output logic                        overrun_o
);

    localparam int LZC_W = $clog2(FX_B) + 1;
    localparam logic [FIR_TE_SIZE-1:0] TE_BIAS = FIR_TE_SIZE'(FX_B - 1 - FX_M);

    fma_norm_state_e    r_state, w_state_n;
    operation_e         r_opq;
    logic               r_sign, w_sign_n;
    logic [FX_B-1:0]    r_mag, w_mag_n;
    logic [LZC_W-1:0]   r_lzc, w_lzc_n;
    logic               r_pend_v, w_pend_v_n;
    logic               r_pend_sign, w_pend_sign_n;
    logic [FX_B-1:0]    r_pend_mag, w_pend_mag_n;
    logic               r_overrun, w_ovr_n;

    logic               w_burst_end;
    logic               w_new_sign;
    logic [FX_B-1:0]    w_new_mag;
    logic               w_valid;
    logic               w_hs;
    logic               w_coarse;
    logic               w_zero;
    logic [FIR_TE_SIZE-1:0] w_te;
    logic               w_load, w_park;
    logic               w_ld_sign;
    logic [FX_B-1:0]    w_ld_mag;

    assign w_burst_end = (op_i != OP_FMADD) && (r_opq == OP_FMADD);
    assign w_new_sign  = fixed_i[FX_B-1];
    // Two's-complement negate; the most-negative value maps to 2^(FX_B-1).
    assign w_new_mag   = w_new_sign ? (~fixed_i + FX_B'(1)) : fixed_i;

    assign w_valid  = (r_state == NORM_OUT);
    assign w_hs     = w_valid && res_if.ready_i;
    assign w_coarse = ~|r_mag[FX_B-1 -: SHIFT_STEP];
    // Normalized non-zero values have MSB set, so an all-zero mag means zero.
    assign w_zero   = (r_mag == '0);
    assign w_te     = w_zero ? '0 : TE_BIAS - FIR_TE_SIZE'(r_lzc);

    assign res_if.fir_o   = w_valid ? {r_sign, w_te, r_mag[FX_B-1 -: FIR_FRAC_SIZE]} : '0;
    assign res_if.zero_o  = w_valid && w_zero;
    assign res_if.valid_o = w_valid;
`ifdef FMA_NORM_STICKY_EN
    assign res_if.sticky_o = w_valid && (|r_mag[FX_B-FIR_FRAC_SIZE-1:0]);
`else
    assign res_if.sticky_o = 1'b0;
`endif
    assign busy_o    = (r_state != NORM_IDLE);
    assign overrun_o = r_overrun;

    always_comb begin
        w_state_n     = r_state;
        w_sign_n      = r_sign;
        w_mag_n       = r_mag;
        w_lzc_n       = r_lzc;
        w_pend_v_n    = r_pend_v;
        w_pend_sign_n = r_pend_sign;
        w_pend_mag_n  = r_pend_mag;
        w_ovr_n       = 1'b0;
        w_load        = 1'b0;
        w_park        = 1'b0;
        w_ld_sign     = w_new_sign;
        w_ld_mag      = w_new_mag;
        unique case (r_state)
            NORM_IDLE: begin
                w_load = w_burst_end;
            end
            NORM_RUN: begin
                if (w_coarse) begin
                    w_mag_n = r_mag << SHIFT_STEP;
                    w_lzc_n = r_lzc + LZC_W'(SHIFT_STEP);
                end else if (!r_mag[FX_B-1]) begin
                    w_mag_n = r_mag << 1;
                    w_lzc_n = r_lzc + LZC_W'(1);
                end else begin
                    w_state_n = NORM_OUT;
                end
                w_park = w_burst_end;
            end
            NORM_OUT: begin
                if (w_hs) begin
                    if (r_pend_v) begin
                        // Pending moves to working; a same-edge burst end refills it.
                        w_load        = 1'b1;
                        w_ld_sign     = r_pend_sign;
                        w_ld_mag      = r_pend_mag;
                        w_pend_v_n    = w_burst_end;
                        w_pend_sign_n = w_new_sign;
                        w_pend_mag_n  = w_new_mag;
                    end else if (w_burst_end) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_n = NORM_IDLE;
                    end
                end else begin
                    w_park = w_burst_end;
                end
            end
            default: begin
                w_state_n = NORM_IDLE;
            end
        endcase
        if (w_park) begin
            if (!r_pend_v) begin
                w_pend_v_n    = 1'b1;
                w_pend_sign_n = w_new_sign;
                w_pend_mag_n  = w_new_mag;
            end else begin
                w_ovr_n = 1'b1;
            end
        end
        if (w_load) begin
            w_sign_n  = w_ld_sign;
            w_mag_n   = w_ld_mag;
            w_lzc_n   = '0;
            w_state_n = (w_ld_mag == '0) ? NORM_OUT : NORM_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= NORM_IDLE;
            r_opq       <= OP_NOP;
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_lzc       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_sign <= 1'b0;
            r_pend_mag  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_opq       <= op_i;
            r_sign      <= w_sign_n;
            r_mag       <= w_mag_n;
            r_lzc       <= w_lzc_n;
            r_pend_v    <= w_pend_v_n;
            r_pend_sign <= w_pend_sign_n;
            r_pend_mag  <= w_pend_mag_n;
            r_overrun   <= w_ovr_n;
        end
    end

endmodule

// File: tb/tb_fma_acc_normalizer.sv
// Directed bench for fma_acc_normalizer: vector table plus
// pending/overrun and mid-operation reset sequences.
module tb_fma_acc_normalizer;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    operation_e  op  = OP_NOP;
    logic [63:0] fx  = '0;
    logic        busy;
    logic        ovr;

    fma_acc_normalizer_if res_if ();

    fma_acc_normalizer dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .op_i      (op),
        .fixed_i   (fx),
        .res_if    (res_if),
        .busy_o    (busy),
        .overrun_o (ovr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] fx;
        int          lat;
        logic        s;
        logic [6:0]  te;
        logic [13:0] mant;
        logic        z;
        logic        st;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [21:0] firv(input logic s, input logic [6:0] te,
                                         input logic [13:0] m);
        return {s, te, m};
    endfunction

    // Burst end is seen at the first posedge after this task returns.
    task automatic burst(input logic [63:0] v);
        @(negedge clk);
        op = OP_FMADD;
        fx = v;
        @(negedge clk);
        op = OP_NOP;
    endtask

    // lat = n where valid first seen after edge k+n; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (res_if.valid_o) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   seen;
        logic exp_st;

        vecs[0] = '{64'h0000_0000_8000_0000,  5, 1'b0, 7'h00, 14'h2000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFE_4000_0000, 11, 1'b1, 7'h01, 14'h3800, 1'b0, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_0000,  0, 1'b0, 7'h00, 14'h0000, 1'b1, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000,  1, 1'b1, 7'h20, 14'h2000, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_0000_0001, 15, 1'b0, 7'h61, 14'h2000, 1'b0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 15, 1'b1, 7'h61, 14'h2000, 1'b0, 1'b0};
        vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF,  2, 1'b0, 7'h1F, 14'h3FFF, 1'b0, 1'b1};
        vecs[7] = '{64'h0000_0000_8000_0001,  5, 1'b0, 7'h00, 14'h2000, 1'b0, 1'b1};

        res_if.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset valid", 64'(res_if.valid_o), 64'd0);
        chk("reset overrun", 64'(ovr), 64'd0);
        chk("reset fir", 64'(res_if.fir_o), 64'd0);
        chk("reset zero", 64'(res_if.zero_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
`ifdef FMA_NORM_STICKY_EN
            exp_st = vecs[i].st;
`else
            exp_st = 1'b0;
`endif
            burst(vecs[i].fx);
            wait_valid(lat);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d fir", i), 64'(res_if.fir_o),
                64'(firv(vecs[i].s, vecs[i].te, vecs[i].mant)));
            chk($sformatf("v%0d zero", i), 64'(res_if.zero_o), 64'(vecs[i].z));
            chk($sformatf("v%0d sticky", i), 64'(res_if.sticky_o), 64'(exp_st));
            @(negedge clk);
            chk($sformatf("v%0d hold valid", i), 64'(res_if.valid_o), 64'd1);
            chk($sformatf("v%0d hold fir", i), 64'(res_if.fir_o),
                64'(firv(vecs[i].s, vecs[i].te, vecs[i].mant)));
            res_if.ready_i = 1'b1;
            @(negedge clk);
            res_if.ready_i = 1'b0;
            chk($sformatf("v%0d valid after hs", i), 64'(res_if.valid_o), 64'd0);
            chk($sformatf("v%0d busy after hs", i), 64'(busy), 64'd0);
        end

        // Three burst ends two cycles apart while the consumer stalls.
        burst(64'h0000_0000_8000_0000);
        @(negedge clk);
        chk("ovr A", 64'(ovr), 64'd0);
        op = OP_FMADD;
        fx = 64'hFFFF_FFFE_4000_0000;
        @(negedge clk);
        op = OP_NOP;
        @(negedge clk);
        chk("ovr B", 64'(ovr), 64'd0);
        op = OP_FMADD;
        fx = 64'h8000_0000_0000_0000;
        @(negedge clk);
        op = OP_NOP;
        @(negedge clk);
        chk("ovr C pulse", 64'(ovr), 64'd1);
        chk("valid before A", 64'(res_if.valid_o), 64'd0);
        @(negedge clk);
        chk("ovr pulse width", 64'(ovr), 64'd0);
        chk("A valid", 64'(res_if.valid_o), 64'd1);
        chk("A fir", 64'(res_if.fir_o), 64'(firv(1'b0, 7'h00, 14'h2000)));
        res_if.ready_i = 1'b1;
        @(negedge clk);
        chk("B busy", 64'(busy), 64'd1);
        chk("B not yet valid", 64'(res_if.valid_o), 64'd0);
        wait_valid(lat);
        chk("B latency", 64'(lat), 64'd10);
        chk("B fir", 64'(res_if.fir_o), 64'(firv(1'b1, 7'h01, 14'h3800)));
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (res_if.valid_o || ovr) seen++;
        end
        chk("no third result", 64'(seen), 64'd0);
        chk("idle after drain", 64'(busy), 64'd0);
        res_if.ready_i = 1'b0;

        // Reset while normalizing with the pending slot full.
        burst(64'h0000_0000_0000_0001);
        burst(64'h0000_0000_8000_0000);
        @(negedge clk);
        chk("busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(res_if.valid_o), 64'd0);
        rst = 1'b0;
        res_if.ready_i = 1'b1;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (res_if.valid_o || busy || ovr) seen++;
        end
        chk("no output after rst", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
